// File: rtl/matrix_mac_engine_if.sv
// Operand/result bus and start/busy/done handshake for matrix_mac_engine.
interface matrix_mac_engine_if #(
  parameter int MAT_N = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW+$clog2(MAT_N)
);
  logic                         start;
  logic [$clog2(MAT_N+1)-1:0]   dim;
  logic                         signed_mode;
  logic [DW-1:0]                mat_A [MAT_N*MAT_N];
  logic [DW-1:0]                mat_B [MAT_N*MAT_N];
  logic                         busy;
  logic                         done;
  logic                         err;
  logic [ACC_W-1:0]             mat_C [MAT_N*MAT_N];

  modport master (
    output start, dim, signed_mode, mat_A, mat_B,
    input  busy, done, err, mat_C
  );

  modport slave (
    input  start, dim, signed_mode, mat_A, mat_B,
    output busy, done, err, mat_C
  );
endinterface

// File: rtl/matrix_mac_engine.sv
// Sequential C = A x B engine: one shared MAC walks (i, j, k), writing one
// C element every D cycles into a registered row-major result array.
module matrix_mac_engine #(
  parameter int MAT_N = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW+$clog2(MAT_N)
)(
  input  logic               clk,
  input  logic               rst_n,
  matrix_mac_engine_if.slave bus
);
  localparam int DIMW = $clog2(MAT_N+1);
  localparam int IDXW = $clog2(MAT_N*MAT_N);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_next;

  logic [DIMW-1:0]  dim_q, i, j, k;
  logic             smode_q;
  logic [ACC_W-1:0] acc, prod, a_ext, b_ext;
  logic [DW-1:0]    a_op, b_op;
  logic [IDXW-1:0]  idx_a, idx_b, idx_c;
  logic             legal, accept, reject, mac_en, fin;
  logic             k_last, j_last, i_last;

  assign legal  = (bus.dim != '0) && (bus.dim <= DIMW'(MAT_N));
  assign k_last = (k == dim_q - DIMW'(1));
  assign j_last = (j == dim_q - DIMW'(1));
  assign i_last = (i == dim_q - DIMW'(1));

  assign idx_a = IDXW'(i) * IDXW'(MAT_N) + IDXW'(k);
  assign idx_b = IDXW'(k) * IDXW'(MAT_N) + IDXW'(j);
  assign idx_c = IDXW'(i) * IDXW'(MAT_N) + IDXW'(j);

  assign a_op = bus.mat_A[idx_a];
  assign b_op = bus.mat_B[idx_b];

  // Extending both operands to ACC_W before multiplying yields the exact
  // two's complement product modulo 2^ACC_W in either mode.
  assign a_ext = smode_q ? {{(ACC_W-DW){a_op[DW-1]}}, a_op} : {{(ACC_W-DW){1'b0}}, a_op};
  assign b_ext = smode_q ? {{(ACC_W-DW){b_op[DW-1]}}, b_op} : {{(ACC_W-DW){1'b0}}, b_op};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept)      state_next = RUN;
        else if (reject) state_next = FIN;
      end
      RUN:     if (k_last && j_last && i_last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    mac_en = 1'b0;
    fin    = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.start & legal;
        reject = bus.start & ~legal;
      end
      RUN:     mac_en = 1'b1;
      FIN:     fin    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      for (int unsigned n = 0; n < MAT_N*MAT_N; n++) bus.mat_C[n] <= '0;
      dim_q    <= '0;
      smode_q  <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
    end else begin
      bus.done <= fin;
      if (fin) bus.busy <= 1'b0;
      if (reject) bus.err <= 1'b1;
      if (accept) begin
        dim_q    <= bus.dim;
        smode_q  <= bus.signed_mode;
        i        <= '0;
        j        <= '0;
        k        <= '0;
        acc      <= '0;
        bus.err  <= 1'b0;
        bus.busy <= 1'b1;
        for (int unsigned n = 0; n < MAT_N*MAT_N; n++) bus.mat_C[n] <= '0;
      end
      if (mac_en) begin
        if (!k_last) begin
          acc <= acc + prod;
          k   <= k + DIMW'(1);
        end else begin
          bus.mat_C[idx_c] <= acc + prod;
          acc <= '0;
          k   <= '0;
          if (j_last) begin
            j <= '0;
            i <= i + DIMW'(1);
          end else begin
            j <= j + DIMW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed self-checking bench for matrix_mac_engine (MAT_N=4, DW=8, ACC_W=18).
module tb_matrix_mac_engine;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_mac_engine_if #(.MAT_N(N), .DW(DW), .ACC_W(AW)) bus();
  matrix_mac_engine #(.MAT_N(N), .DW(DW), .ACC_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_c [N*N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int n = 0; n < N*N; n++) begin
      bus.mat_A[n] = a;
      bus.mat_B[n] = b;
    end
  endtask

  task automatic set_exp(input int d, input logic [AW-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_c[r*N+c] = (r < d && c < d) ? v : '0;
  endtask

  // Small 2x2 operands: A = [[a00,2],[3,4]], B = [[5,6],[7,8]]
  task automatic load_2x2(input logic [DW-1:0] a00);
    fill(8'd0, 8'd0);
    bus.mat_A[0] = a00;  bus.mat_A[1] = 8'd2;  bus.mat_A[4] = 8'd3;  bus.mat_A[5] = 8'd4;
    bus.mat_B[0] = 8'd5; bus.mat_B[1] = 8'd6;  bus.mat_B[4] = 8'd7;  bus.mat_B[5] = 8'd8;
  endtask

  task automatic run_op(input int d, input logic sm, output int lat, output logic busy_seen);
    bus.dim         = 3'(d);
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_seen = bus.busy;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dim = '0; bus.signed_mode = 1'b0;
    fill(8'd0, 8'd0);
    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b expected 0 0 0", bus.busy, bus.done, bus.err);
    end
    set_exp(0, '0);
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL reset C[%0d]: got %0d expected %0d", n, bus.mat_C[n], exp_c[n]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int lat;
    logic bs;
    fill(8'd0, 8'hAA);
    set_exp(0, '0);
    for (int r = 0; r < 3; r++) begin
      bus.mat_A[r*N+r] = 8'd1;
      for (int c = 0; c < 3; c++) begin
        bus.mat_B[r*N+c] = 8'(r*3+c+1);
        exp_c[r*N+c]     = AW'(r*3+c+1);
      end
    end
    run_op(3, 1'b0, lat, bs);
    checks++;
    if (bs !== 1'b1) begin errors++; $display("FAIL identity busy_after_start: got %b expected 1", bs); end
    checks++;
    if (lat !== 28) begin errors++; $display("FAIL identity latency: got %0d expected 28", lat); end
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL identity done_flags: busy=%b err=%b expected 0 0", bus.busy, bus.err);
    end
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL identity C[%0d]: got %0d expected %0d", n, bus.mat_C[n], exp_c[n]);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL identity done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_unsigned_max();
    int lat;
    logic bs;
    fill(8'hFF, 8'hFF);
    set_exp(4, 18'd260100);
    run_op(4, 1'b0, lat, bs);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL umax latency: got %0d expected 65", lat); end
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL umax C[%0d]: got %0d expected %0d", n, bus.mat_C[n], exp_c[n]);
      end
    end
  endtask

  task automatic test_signed();
    int lat;
    logic bs;
    logic [DW-1:0] av [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
    logic [DW-1:0] bv [4] = '{8'h80, 8'h80, 8'h01, 8'h01};
    logic          sm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] ev [4] = '{18'd49152, 18'd49152, 18'h3FFFD, 18'd765};
    for (int t = 0; t < 4; t++) begin
      fill(av[t], bv[t]);
      set_exp(3, ev[t]);
      run_op(3, sm[t], lat, bs);
      checks++;
      if (lat !== 28) begin errors++; $display("FAIL signed%0d latency: got %0d expected 28", t, lat); end
      for (int n = 0; n < N*N; n++) begin
        checks++;
        if (bus.mat_C[n] !== exp_c[n]) begin
          errors++;
          $display("FAIL signed%0d C[%0d]: got %h expected %h", t, n, bus.mat_C[n], exp_c[n]);
        end
      end
    end
  endtask

  task automatic test_illegal_dim();
    int bad [2] = '{0, 5};
    for (int t = 0; t < 2; t++) begin
      bus.dim   = 3'(bad[t]);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d accept: err=%b busy=%b done=%b expected 1 0 0", bad[t], bus.err, bus.busy, bus.done);
      end
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b1) begin
        errors++;
        $display("FAIL illegal%0d done: done=%b busy=%b err=%b expected 1 0 1", bad[t], bus.done, bus.busy, bus.err);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.err !== 1'b1) begin
        errors++;
        $display("FAIL illegal%0d after: done=%b err=%b expected 0 1", bad[t], bus.done, bus.err);
      end
      for (int n = 0; n < N*N; n++) begin
        checks++;
        if (bus.mat_C[n] !== exp_c[n]) begin
          errors++;
          $display("FAIL illegal%0d C[%0d]: got %h expected %h", bad[t], n, bus.mat_C[n], exp_c[n]);
        end
      end
    end
  endtask

  // start re-pulsed and dim/signed_mode disturbed while busy: one op, one done
  task automatic test_protocol();
    int dones = 0;
    int lat   = 0;
    load_2x2(8'hFF);
    set_exp(0, '0);
    exp_c[0] = 18'd1289; exp_c[1] = 18'd1546; exp_c[4] = 18'd43; exp_c[5] = 18'd50;
    bus.dim = 3'd2; bus.signed_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL protocol accept: busy=%b err=%b expected 1 0", bus.busy, bus.err);
    end
    bus.dim = 3'd1; bus.signed_mode = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.done === 1'b1) begin
        dones++;
        if (lat == 0) lat = n;
        bus.start = 1'b0;
      end else if (bus.busy === 1'b1) begin
        bus.start = ~bus.start;
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL protocol done_count: got %0d expected 1", dones); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL protocol latency: got %0d expected 9", lat); end
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL protocol C[%0d]: got %0d expected %0d", n, bus.mat_C[n], exp_c[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bs;
    load_2x2(8'd1);
    bus.mat_A[0] = 8'd2; bus.mat_A[1] = 8'd0; bus.mat_A[4] = 8'd0; bus.mat_A[5] = 8'd2;
    run_op(2, 1'b0, lat, bs);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL b2b_first latency: got %0d expected 9", lat); end
    set_exp(0, '0);
    exp_c[0] = 18'd10; exp_c[1] = 18'd12; exp_c[4] = 18'd14; exp_c[5] = 18'd16;
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL b2b_first C[%0d]: got %0d expected %0d", n, bus.mat_C[n], exp_c[n]);
      end
    end
    // still in the done cycle: issue the next start immediately
    load_2x2(8'd1);
    run_op(2, 1'b0, lat, bs);
    checks++;
    if (lat !== 9 || bs !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second latency/busy: got %0d/%b expected 9/1", lat, bs);
    end
    exp_c[0] = 18'd19; exp_c[1] = 18'd22; exp_c[4] = 18'd43; exp_c[5] = 18'd50;
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL b2b_second C[%0d]: got %0d expected %0d", n, bus.mat_C[n], exp_c[n]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic bs;
    fill(8'hFF, 8'hFF);
    bus.dim = 3'd4; bus.signed_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL midreset flags: busy=%b done=%b err=%b expected 0 0 0", bus.busy, bus.done, bus.err);
    end
    set_exp(0, '0);
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL midreset C[%0d]: got %0d expected 0", n, bus.mat_C[n]);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load_2x2(8'd1);
    run_op(2, 1'b0, lat, bs);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL postreset latency: got %0d expected 9", lat); end
    exp_c[0] = 18'd19; exp_c[1] = 18'd22; exp_c[4] = 18'd43; exp_c[5] = 18'd50;
    for (int n = 0; n < N*N; n++) begin
      checks++;
      if (bus.mat_C[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL postreset C[%0d]: got %0d expected %0d", n, bus.mat_C[n], exp_c[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_unsigned_max();
    test_signed();
    test_illegal_dim();
    test_protocol();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
